// File: rtl/fb_writer_if.sv
// Pixel-stream and SDRAM burst-write signal bundle for fb_writer.
// The master modport is the DMA side; the slave modport is the producer/controller side.
interface fb_writer_if #(
  parameter int DATA_W = 16
);
  logic              pix_valid_i;
  logic              pix_ready_o;
  logic [DATA_W-1:0] pix_data_i;
  logic              sdram_wr;
  logic              sdram_rdy;
  logic              sdram_ack;
  logic [23:0]       sdram_addr_x16;
  logic [DATA_W-1:0] sdram_wdata;

  modport master (
    input  pix_valid_i, pix_data_i, sdram_rdy,
    output pix_ready_o, sdram_wr, sdram_ack, sdram_addr_x16, sdram_wdata
  );

  modport slave (
    output pix_valid_i, pix_data_i, sdram_rdy,
    input  pix_ready_o, sdram_wr, sdram_ack, sdram_addr_x16, sdram_wdata
  );
endinterface

// File: rtl/fb_writer.sv
// Burst-write DMA: buffers RGB565 pixels in a two-burst FWFT FIFO and writes them
// to the SDRAM framebuffer in full bursts only, so a burst never starves mid-transfer.
module fb_writer #(
  parameter int          BURST_LEN   = 64,
  parameter int          BURST_BITS  = 6,
  parameter int          FRAME_WORDS = 76800,
  parameter logic [5:0]  FB_PAGE     = 6'h20,
  parameter int          DATA_W      = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  fb_writer_if.master   bus
);

  localparam int                    FIFO_DEPTH = 2 * BURST_LEN;
  localparam int                    PTR_W      = BURST_BITS + 1;
  localparam int                    CNT_W      = BURST_BITS + 2;
  localparam logic [CNT_W-1:0]      FIFO_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      BURST_CNT  = CNT_W'(BURST_LEN);
  localparam logic [16:0]           FRAME_CNT  = 17'(FRAME_WORDS);
  localparam logic [16:0]           OUT_STEP   = 17'(BURST_LEN);
  localparam logic [17:0]           ADDR_STEP  = 18'(BURST_LEN);
  localparam logic [BURST_BITS-1:0] LAST_BEAT  = BURST_BITS'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BURST = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t                 state;
  logic [DATA_W-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;
  logic [16:0]            in_count;
  logic [16:0]            out_count;
  logic [17:0]            addr_off;
  logic [BURST_BITS-1:0]  beat;
  logic                   wr_q;
  logic                   ack_q;
  logic                   fifo_full;
  logic                   pix_ready;
  logic                   push;
  logic                   pop;

  assign fifo_full = (fifo_cnt == FIFO_FULL);
  assign pix_ready = busy_o && !fifo_full && (in_count < FRAME_CNT);
  assign push      = bus.pix_valid_i && pix_ready;
  // wr_q is only ever high in BURST, so a transfer is exactly wr && rdy.
  assign pop       = wr_q && bus.sdram_rdy;

  assign bus.pix_ready_o    = pix_ready;
  assign bus.sdram_wr       = wr_q;
  assign bus.sdram_ack      = ack_q;
  assign bus.sdram_addr_x16 = {FB_PAGE, addr_off};
  assign bus.sdram_wdata    = fifo_mem[rd_ptr];

  // FIFO storage: pure data, no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= bus.pix_data_i;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave the count unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Frame sequencer: IDLE -> FILL -> BURST -> ACK -> (FILL | IDLE).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      wr_q      <= 1'b0;
      ack_q     <= 1'b0;
      in_count  <= '0;
      out_count <= '0;
      addr_off  <= '0;
      beat      <= '0;
    end else begin
      done_o <= 1'b0;
      if (push) begin
        in_count <= in_count + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            in_count  <= '0;
            out_count <= '0;
            addr_off  <= '0;
            busy_o    <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          if (fifo_cnt >= BURST_CNT) begin
            wr_q  <= 1'b1;
            beat  <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (pop) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              wr_q      <= 1'b0;
              ack_q     <= 1'b1;
              addr_off  <= addr_off + ADDR_STEP;
              out_count <= out_count + OUT_STEP;
              state     <= ACK;
            end
          end
        end
        ACK: begin
          ack_q <= 1'b0;
          if (out_count == FRAME_CNT) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            state <= FILL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Randomized bench for fb_writer: a producer feeds pixels, a scoreboard expects every
// accepted pixel to reach SDRAM once, in order, at base + 64*burst.
module tb_fb_writer;

  localparam int          BURST_LEN   = 64;
  localparam int          SMALL_FRAME = 128;
  localparam int          BIG_FRAME   = 19200;
  localparam logic [23:0] FB_BASE     = 24'h800000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_s, busy_s, done_s;
  logic start_b, busy_b, done_b;

  fb_writer_if #(.DATA_W(16)) bus_s ();
  fb_writer_if #(.DATA_W(16)) bus_b ();

  fb_writer #(.BURST_LEN(64), .BURST_BITS(6), .FRAME_WORDS(SMALL_FRAME),
              .FB_PAGE(6'h20), .DATA_W(16)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(start_s),
    .busy_o(busy_s), .done_o(done_s), .bus(bus_s));

  fb_writer #(.BURST_LEN(64), .BURST_BITS(6), .FRAME_WORDS(BIG_FRAME),
              .FB_PAGE(6'h20), .DATA_W(16)) u_big (
    .clk_i(clk), .rst_i(rst), .start_i(start_b),
    .busy_o(busy_b), .done_o(done_b), .bus(bus_b));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int sel   = 0;

  // producer / controller knobs
  bit          prod_en, prod_rand, prod_seq, start_req;
  logic [15:0] cur_data;
  int          prod_sent, prod_limit, rdy_mode;

  // scoreboard state
  logic [15:0] exp_q[$];
  int          beat_m, burst_m, done_m, acc_m, word_m, rise_n, rise1, rise2;
  logic [23:0] last_addr;
  logic        prev_wr;

  // sampled DUT view
  logic        m_rst, m_start, m_busy, m_done, m_valid, m_ready, m_wr, m_rdy, m_ack;
  logic [15:0] m_data, m_wdata;
  logic [23:0] m_addr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic drive();
    logic v, r;
    v = prod_en && (prod_sent < prod_limit) && (!prod_rand || ($urandom_range(0, 3) != 0));
    case (rdy_mode)
      0:       r = 1'b1;
      1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       r = 1'b0;
      default: r = 1'($urandom_range(0, 1));
    endcase
    if (sel == 0) begin
      bus_s.pix_valid_i = v;  bus_s.pix_data_i = cur_data;  bus_s.sdram_rdy = r;  start_s = start_req;
      bus_b.pix_valid_i = 0;  bus_b.pix_data_i = '0;        bus_b.sdram_rdy = 0;  start_b = 0;
    end else begin
      bus_b.pix_valid_i = v;  bus_b.pix_data_i = cur_data;  bus_b.sdram_rdy = r;  start_b = start_req;
      bus_s.pix_valid_i = 0;  bus_s.pix_data_i = '0;        bus_s.sdram_rdy = 0;  start_s = 0;
    end
    start_req = 1'b0;
  endtask

  task automatic sample();
    m_rst = rst;
    if (sel == 0) begin
      m_start = start_s; m_busy = busy_s; m_done = done_s;
      m_valid = bus_s.pix_valid_i; m_ready = bus_s.pix_ready_o; m_data = bus_s.pix_data_i;
      m_wr = bus_s.sdram_wr; m_rdy = bus_s.sdram_rdy; m_ack = bus_s.sdram_ack;
      m_addr = bus_s.sdram_addr_x16; m_wdata = bus_s.sdram_wdata;
    end else begin
      m_start = start_b; m_busy = busy_b; m_done = done_b;
      m_valid = bus_b.pix_valid_i; m_ready = bus_b.pix_ready_o; m_data = bus_b.pix_data_i;
      m_wr = bus_b.sdram_wr; m_rdy = bus_b.sdram_rdy; m_ack = bus_b.sdram_ack;
      m_addr = bus_b.sdram_addr_x16; m_wdata = bus_b.sdram_wdata;
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    beat_m = 0; burst_m = 0; done_m = 0; acc_m = 0; word_m = 0;
    rise_n = 0; rise1 = 0; rise2 = 0; last_addr = '0;
  endtask

  task automatic monitor();
    logic [23:0] exp_addr;
    if (m_rst) begin
      clear_model();
      prev_wr = 1'b0;
      return;
    end
    if (m_start && !m_busy) clear_model();
    if (m_valid && m_ready) begin
      exp_q.push_back(m_data);
      acc_m++;
      prod_sent++;
      cur_data = prod_seq ? cur_data + 16'd1 : 16'($urandom);
    end
    if (m_wr && !prev_wr) begin
      rise_n++;
      if (rise_n == 1) rise1 = cyc;
      if (rise_n == 2) rise2 = cyc;
    end
    if (m_wr && m_rdy) begin
      exp_addr = FB_BASE + 24'(burst_m * BURST_LEN);
      check_eq("burst_addr", m_addr, exp_addr);
      check_eq("word_avail", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check_eq("wdata", m_wdata, exp_q.pop_front());
      beat_m++;
      word_m++;
      last_addr = m_addr;
    end
    if (m_ack) begin
      check_eq("wr_during_ack", m_wr, 0);
      check_eq("ack_beats", beat_m, BURST_LEN);
      beat_m = 0;
      burst_m++;
    end
    if (m_done) begin
      done_m++;
      check_eq("busy_at_done", m_busy, 0);
    end
    prev_wr = m_wr;
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    sample();
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (done_m == 0 && n < budget);
    repeat (4) tick();
  endtask

  task automatic new_frame(input bit seq, input bit rnd_valid, input int limit, input int rmode);
    prod_en = 1'b1; prod_seq = seq; prod_rand = rnd_valid;
    prod_sent = 0; prod_limit = limit; rdy_mode = rmode;
    cur_data = seq ? 16'h0000 : 16'($urandom);
    start_req = 1'b1;
  endtask

  task automatic frame_checks(input string pfx, input int bursts, input int words, input logic [23:0] laddr);
    check_eq({pfx, "_done_once"}, done_m, 1);
    check_eq({pfx, "_bursts"}, burst_m, bursts);
    check_eq({pfx, "_words"}, word_m, words);
    check_eq({pfx, "_leftover"}, exp_q.size(), 0);
    check_eq({pfx, "_busy_end"}, m_busy, 0);
    check_eq({pfx, "_last_addr"}, last_addr, laddr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, k;
    bit  wr_any;
    prod_en = 0; prod_rand = 0; prod_seq = 0; start_req = 0;
    cur_data = '0; prod_sent = 0; prod_limit = 0; rdy_mode = 0;
    prev_wr = 1'b0;
    clear_model();
    rst = 1'b1;
    repeat (3) tick();

    // reset state
    check_eq("rst_wr", bus_s.sdram_wr, 0);
    check_eq("rst_ack", bus_s.sdram_ack, 0);
    check_eq("rst_busy", busy_s, 0);
    check_eq("rst_done", done_s, 0);
    check_eq("rst_pix_ready", bus_s.pix_ready_o, 0);
    check_eq("rst_addr", bus_s.sdram_addr_x16, FB_BASE);
    rst = 1'b0;
    repeat (2) tick();

    // two back-to-back bursts, sequential data, rdy high
    new_frame(1'b1, 1'b0, SMALL_FRAME, 0);
    run_until_done(1000);
    frame_checks("seq", 2, SMALL_FRAME, FB_BASE + 24'h40);
    check_eq("seq_burst_period", rise2 - rise1, BURST_LEN + 2);

    // 63 pixels must not start a burst; the 64th must
    new_frame(1'b0, 1'b0, 63, 0);
    wr_any = 1'b0;
    repeat (100) begin
      tick();
      if (m_wr) wr_any = 1'b1;
    end
    check_eq("p63_no_wr", wr_any, 0);
    check_eq("p63_accepted", acc_m, 63);
    prod_limit = 64;
    k = 0;
    do begin
      tick();
      k++;
    end while (!m_wr && k < 10);
    check_eq("p64_wr_within_2", 32'(k <= 3), 1);
    prod_limit = SMALL_FRAME;
    run_until_done(1000);
    frame_checks("p64", 2, SMALL_FRAME, FB_BASE + 24'h40);

    // rdy pattern 1,0,0,1 with a bursty producer
    new_frame(1'b0, 1'b1, SMALL_FRAME, 1);
    run_until_done(3000);
    frame_checks("rdy1001", 2, SMALL_FRAME, FB_BASE + 24'h40);

    // asynchronous reset in the middle of a burst
    new_frame(1'b0, 1'b0, SMALL_FRAME, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_wr && n < 500);
    repeat (10) tick();
    check_eq("pre_rst_wr", bus_s.sdram_wr, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async_wr", bus_s.sdram_wr, 0);
    check_eq("rst_async_busy", busy_s, 0);
    check_eq("rst_async_ready", bus_s.pix_ready_o, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    new_frame(1'b0, 1'b1, SMALL_FRAME, 3);
    run_until_done(3000);
    frame_checks("after_rst", 2, SMALL_FRAME, FB_BASE + 24'h40);

    // long frame: SDRAM stalls first, then a start pulse mid-frame
    sel = 1;
    new_frame(1'b0, 1'b0, BIG_FRAME, 2);
    repeat (200) tick();
    check_eq("stall_accepted", acc_m, 2 * BURST_LEN);
    check_eq("stall_ready_low", m_ready, 0);
    check_eq("stall_words", word_m, 0);
    rdy_mode = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (acc_m < 5000 && n < 10000);
    start_req = 1'b1;
    run_until_done(30000);
    frame_checks("big", BIG_FRAME / BURST_LEN, BIG_FRAME, FB_BASE + 24'(BIG_FRAME - BURST_LEN));
    repeat (5) tick();
    check_eq("big_done_still_once", done_m, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
